// File: rtl/score_board_pkg.sv
// Shared types for the register producer tracker.
// Select word layout is consumed directly by the bypass mux.
package score_board_pkg;

    localparam int REG_WIDTH = 5;

    typedef logic [REG_WIDTH-1:0] REG_ADDR;

    typedef struct packed {
        logic [2:0] position;
        logic       line;
    } SCORE_BOARD_DATA;

    localparam logic [2:0] POS_EXEC = 3'b100;

endpackage

// File: rtl/score_board_entry.sv
// One architectural register's producer record.
// Shifts toward commit on advance; a new write replaces it.
module score_board_entry
    import score_board_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            advance,
    input  logic            wr_en,
    input  logic            wr_line,
    input  logic            wr_load,
    output SCORE_BOARD_DATA data,
    output logic            load_pend
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data      <= '0;
            load_pend <= 1'b0;
        end else if (advance) begin
            if (wr_en) begin
                data.position <= POS_EXEC;
                data.line     <= wr_line;
                load_pend     <= wr_load;
            end else begin
                data.position <= data.position >> 1;
                load_pend     <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/score_board.sv
// Per-register producer tracker for the dual-issue pipeline.
// Drives bypass select words and load-use stalls toward issue.
module score_board
    import score_board_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int NUM_SRC  = 4
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            advance,
    input  logic                            flush,
    input  logic            [1:0]           issue_valid,
    input  REG_ADDR         [1:0]           issue_dest,
    input  logic            [1:0]           issue_is_load,
    input  REG_ADDR         [NUM_SRC-1:0]   src_addr,
    output SCORE_BOARD_DATA [NUM_SRC-1:0]   score_board_data,
    output logic            [NUM_SRC-1:0]   src_stall,
    output logic                            issue_ready
);

    SCORE_BOARD_DATA    ent_data [NUM_REGS];
    logic               ent_lp   [NUM_REGS];
    logic               issue_ok;
    logic [NUM_SRC-1:0] src_used;

    assign issue_ok    = advance && !flush;
    assign ent_data[0] = '0;
    assign ent_lp[0]   = 1'b0;

    // Lane 1 is younger, so its hit wins on a shared destination.
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
        logic hit0;
        logic hit1;

        assign hit0 = issue_valid[0] && (issue_dest[0] == REG_ADDR'(r));
        assign hit1 = issue_valid[1] && (issue_dest[1] == REG_ADDR'(r));

        score_board_entry u_entry (
            .clk       (clk),
            .resetn    (resetn),
            .advance   (advance),
            .wr_en     (issue_ok && (hit0 || hit1)),
            .wr_line   (hit1),
            .wr_load   (hit1 ? issue_is_load[1] : issue_is_load[0]),
            .data      (ent_data[r]),
            .load_pend (ent_lp[r])
        );
    end

    always_comb begin
        score_board_data = '0;
        src_stall        = '0;
        src_used         = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            score_board_data[k] = ent_data[src_addr[k]];
            src_stall[k]        = ent_lp[src_addr[k]]
                                & ent_data[src_addr[k]].position[2];
            src_used[k]         = (src_addr[k] != '0);
        end
    end

    assign issue_ready = ~|(src_stall & src_used);

endmodule
